// File: rtl/quick_spi_master_if.sv
// TX/RX element stream between the register/DMA front end and quick_spi_master.
// The front end uses the master modport; the SPI engine uses the slave modport.
interface quick_spi_master_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid
  );
endinterface

// File: rtl/quick_spi_master.sv
// Parametrised SPI master: all CPOL/CPHA modes, runtime divider, multi-element bursts.
// Optional LSB_FIRST_EN: shift elements LSB first instead of MSB first.
module quick_spi_master #(
  parameter int unsigned NUMBER_OF_SLAVES  = 2,
  parameter int unsigned SLAVE_INDEX_WIDTH = 1,
  parameter int unsigned DATA_WIDTH        = 16,
  parameter int unsigned CLK_DIV_WIDTH     = 8,
  parameter int unsigned BURST_WIDTH       = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         start_i,
  input  logic [SLAVE_INDEX_WIDTH-1:0] slave_i,
  input  logic                         cpol_i,
  input  logic                         cpha_i,
  input  logic [CLK_DIV_WIDTH-1:0]     clk_div_i,
  input  logic [BURST_WIDTH-1:0]       burst_len_i,
  input  logic [7:0]                   gap_halfs_i,
  quick_spi_master_if.slave            stream,
  output logic                         busy_o,
  output logic                         mosi_o,
  input  logic                         miso_i,
  output logic                         sclk_o,
  output logic [NUMBER_OF_SLAVES-1:0]  ss_n_o
);

  localparam int unsigned BitCntW = $clog2(DATA_WIDTH) + 1;
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);
`ifdef LSB_FIRST_EN
  localparam bit LsbFirst = 1'b1;
`else
  localparam bit LsbFirst = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StLoad, StSetup, StShift, StGap, StHold, StDone} state_e;
  state_e state_q, state_d;

  logic [SLAVE_INDEX_WIDTH-1:0] slave_q, slave_d;
  logic                         cpol_q, cpol_d, cpha_q, cpha_d;
  logic [CLK_DIV_WIDTH-1:0]     div_q, div_d, div_cnt_q, div_cnt_d;
  logic [BURST_WIDTH-1:0]       remain_q, remain_d;
  logic [7:0]                   gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic [BitCntW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]        tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
  logic                         rx_valid_q, rx_valid_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic [NUMBER_OF_SLAVES-1:0]  ss_n_q, ss_n_d, sel_n;

  logic                  tick, leading, last_edge, more, gap_end;
  logic [DATA_WIDTH-1:0] tx_shifted, rx_shifted;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] v);
    return LsbFirst ? v[0] : v[DATA_WIDTH-1];
  endfunction

  assign tick       = (div_cnt_q == div_q);
  // sclk still at its idle level means the coming edge is the leading one of a bit
  assign leading    = (sclk_q == cpol_q);
  assign last_edge  = tick && !leading && (bit_cnt_q == LastBit);
  assign more       = (remain_q > BURST_WIDTH'(1));
  assign gap_end    = tick && (gap_cnt_q == gap_q - 8'd1);
  assign tx_shifted = LsbFirst ? (tx_sr_q >> 1) : (tx_sr_q << 1);
  assign rx_shifted = LsbFirst ? {miso_i, rx_sr_q[DATA_WIDTH-1:1]}
                               : {rx_sr_q[DATA_WIDTH-2:0], miso_i};

  // Out-of-range slave index selects no line
  always_comb begin
    for (int i = 0; i < NUMBER_OF_SLAVES; i++) begin
      sel_n[i] = (int'(slave_q) != i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StLoad;
      StLoad:  if (stream.tx_valid) state_d = StSetup;
      StSetup: if (tick) state_d = StShift;
      StShift: if (last_edge) state_d = !more ? StHold : (gap_q != 8'd0) ? StGap : StLoad;
      StGap:   if (gap_end) state_d = StLoad;
      StHold:  if (tick) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o          = (state_q != StIdle) && (state_q != StDone);
    stream.tx_ready = (state_q == StLoad) && stream.tx_valid;
    sclk_o          = (state_q == StIdle) ? cpol_i : sclk_q;
  end

  assign mosi_o          = mosi_q;
  assign ss_n_o          = ss_n_q;
  assign stream.rx_data  = rx_data_q;
  assign stream.rx_valid = rx_valid_q;

  always_comb begin
    slave_d    = slave_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    div_d      = div_q;
    remain_d   = remain_q;
    gap_d      = gap_q;
    gap_cnt_d  = gap_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    ss_n_d     = ss_n_q;
    div_cnt_d  = '0;
    if ((state_q inside {StSetup, StShift, StGap, StHold}) && !tick) begin
      div_cnt_d = div_cnt_q + CLK_DIV_WIDTH'(1);
    end
    unique case (state_q)
      StIdle: if (start_i) begin
        slave_d  = slave_i;
        cpol_d   = cpol_i;
        cpha_d   = cpha_i;
        div_d    = clk_div_i;
        remain_d = (burst_len_i == '0) ? BURST_WIDTH'(1) : burst_len_i;
        gap_d    = gap_halfs_i;
        sclk_d   = cpol_i;
      end
      StLoad: if (stream.tx_valid) begin
        tx_sr_d   = stream.tx_data;
        ss_n_d    = sel_n;
        bit_cnt_d = '0;
        gap_cnt_d = '0;
        if (!cpha_q) mosi_d = first_bit(stream.tx_data);
      end
      StShift: if (tick) begin
        sclk_d = ~sclk_q;
        if (leading) begin
          if (cpha_q) begin
            mosi_d  = first_bit(tx_sr_q);
            tx_sr_d = tx_shifted;
          end else begin
            rx_sr_d = rx_shifted;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BitCntW'(1);
          if (cpha_q) begin
            rx_sr_d = rx_shifted;
          end else begin
            tx_sr_d = tx_shifted;
            mosi_d  = first_bit(tx_shifted);
          end
        end
        if (last_edge) begin
          rx_data_d  = rx_sr_d;
          rx_valid_d = 1'b1;
          remain_d   = remain_q - BURST_WIDTH'(1);
        end
      end
      StGap: if (tick) gap_cnt_d = gap_cnt_q + 8'd1;
      StHold: if (tick) begin
        ss_n_d = '1;
        mosi_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      slave_q    <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      div_q      <= '0;
      div_cnt_q  <= '0;
      remain_q   <= '0;
      gap_q      <= '0;
      gap_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ss_n_q     <= '1;
    end else begin
      slave_q    <= slave_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      div_q      <= div_d;
      div_cnt_q  <= div_cnt_d;
      remain_q   <= remain_d;
      gap_q      <= gap_d;
      gap_cnt_q  <= gap_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      ss_n_q     <= ss_n_d;
    end
  end

endmodule

// File: doc/quick_spi_master.md
Name: quick_spi_master

Overview:
- Parametrised SPI master; successor to the fixed-format SPI engine.
- Generalised over data width, slave count, all four CPOL/CPHA modes, runtime clock divider and multi-element bursts.
- TX data arrives on a valid/ready stream; RX data leaves as single-cycle valid pulses.
- Sits between a register/DMA front end and the external SPI pins.

Parameters:
NUMBER_OF_SLAVES, 2, number of ss_n lines
SLAVE_INDEX_WIDTH, 1, width of slave index port
DATA_WIDTH, 16, bits per element (2..32)
CLK_DIV_WIDTH, 8, width of clk_div
BURST_WIDTH, 8, width of burst_len

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin transaction (sampled in IDLE only)
slave  in  SLAVE_INDEX_WIDTH  target slave index
cpol  in  1  clock polarity (latched at start)
cpha  in  1  clock phase (latched at start)
clk_div  in  CLK_DIV_WIDTH  sclk half-period = clk_div+1 clk cycles
burst_len  in  BURST_WIDTH  elements per transaction; 0 treated as 1
gap_halfs  in  8  idle sclk half-periods between elements
tx_data  in  DATA_WIDTH  outgoing element
tx_valid  in  1  tx_data valid
tx_ready  out  1  element accepted this cycle
rx_data  out  DATA_WIDTH  received element
rx_valid  out  1  one-cycle pulse, rx_data valid
busy  out  1  transaction in progress
mosi  out  1  serial out
miso  in  1  serial in
sclk  out  1  serial clock
ss_n  out  NUMBER_OF_SLAVES  active-low selects

Behaviour:
- Reset, applied synchronously at any time including mid-transfer: state IDLE, sclk=0, ss_n all 1, mosi=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0, all counters 0.
- Clocking: the half-period counter counts 0..clk_div. An sclk edge occurs when it wraps. clk_div=0 gives sclk = clk/2.
- IDLE:
  - sclk=cpol (live), busy=0.
  - start=1 latches slave, cpol, cpha, clk_div, burst_len and gap_halfs, then goes to LOAD. busy=1 from the next cycle.
- LOAD:
  - Waits for tx_valid. tx_ready=1 for exactly the cycle tx_valid=1 is seen; tx_data is captured into the shift register.
  - The first element also asserts ss_n[slave]=0. An out-of-range slave asserts no line, but the transfer still runs.
  - Next state is SETUP.
  - A tx underrun (tx_valid=0) holds LOAD indefinitely with sclk at idle level and ss_n held.
- SETUP:
  - One half-period.
  - CPHA=0: MSB is driven on mosi on entry.
- SHIFT:
  - Runs 2*DATA_WIDTH sclk edges. Leading edge = first edge of each bit.
  - CPHA=0: sample miso on leading edge, drive next bit on trailing edge.
  - CPHA=1: drive bit on leading edge, sample on trailing edge.
  - After the final edge, rx_valid pulses on the next clk cycle with the full element.
- Element end:
  - If elements remain: go to GAP (gap_halfs>0) or directly to LOAD.
  - Otherwise: go to HOLD.
- GAP: gap_halfs half-periods, sclk idle, ss_n held low; then LOAD.
- HOLD:
  - One half-period; then ss_n all 1, mosi=0.
  - Then DONE for one cycle (busy=0 from DONE), then IDLE.
- start while busy=1 is ignored.
- sclk returns to cpol at the end of every element. The edge count is fixed, so the level is always correct.
- Element counter width BURST_WIDTH. burst_len=255 gives 255 elements, no wrap.
- Arithmetic: half-period counter CLK_DIV_WIDTH bits; bit counter clog2(DATA_WIDTH)+1 bits.

Optional Feature:
LSB_FIRST_EN:
- Defined: elements are shifted out and in LSB first; rx_data bit 0 holds the first bit received.
- Undefined: MSB first; rx_data bit DATA_WIDTH-1 holds the first bit received.
- Handshake, timing and edge counts are identical in both builds.

Test Plan:
- Mode 0, clk_div=1, burst_len=1, tx_data=16'h1A6A, miso looped to mosi -> 32 sclk edges, each half-period 2 clk; rx_data=16'h1A6A; rx_valid 1 pulse; ss_n[0] low throughout, then high; busy drops.
- All four cpol/cpha combos, tx=16'hA5C3, slave model returning 16'h3C5A -> mosi stable at every sampling edge; rx_data=16'h3C5A; sclk idle level equals cpol before and after.
- burst_len=3, gap_halfs=2, tx_valid tied 1 -> three tx_ready pulses and three rx_valid pulses; 2 idle half-periods between elements; ss_n stays low across the whole burst.
- Underrun: tx_valid dropped for 20 cycles before element 2 -> sclk frozen at cpol, ss_n held low; resumes cleanly when valid returns; data is correct.
- Reset asserted at bit 7 of element 1 -> next cycle ss_n=all 1, sclk=0, busy=0, no rx_valid; a new start then completes normally.
- slave=1 with NUMBER_OF_SLAVES=2, plus start pulsed while busy -> only ss_n[1] toggles; the second start is ignored and exactly one transaction occurs.
